// File: rtl/shift_pkg.sv
// Shared definitions for the parametrised shift register.
// Provides the 3-bit operation encoding, the shift-engine state enum and a
// helper that identifies operations usable by the multi-step engine.
package shift_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_LOAD = 3'b001;
  localparam mode_t MODE_SHL  = 3'b010;
  localparam mode_t MODE_SHR  = 3'b011;
  localparam mode_t MODE_ASR  = 3'b100;
  localparam mode_t MODE_ROL  = 3'b101;
  localparam mode_t MODE_ROR  = 3'b110;
  localparam mode_t MODE_RSVD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  // True for the shift/rotate operations (010..110) the engine can repeat.
  function automatic logic is_shift_mode(input mode_t m);
    return (m >= MODE_SHL) && (m <= MODE_ROR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-step shift/rotate network, purely combinational.
// Ports:
//   q        current register value
//   op       operation select (shift_pkg encoding)
//   ser_in_l fill bit entering at the MSB for logical shift right
//   ser_in_r fill bit entering at the LSB for shift left
//   next_q   register value after applying op once
// Hold, load and the reserved code pass q through; the parallel load is
// handled by the owning register.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_t            op,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  output logic [WIDTH-1:0] next_q
);

  always_comb begin
    next_q = q;
    unique case (op)
      MODE_SHL: next_q = {q[WIDTH-2:0], ser_in_r};
      MODE_SHR: next_q = {ser_in_l, q[WIDTH-1:1]};
      MODE_ASR: next_q = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_ROL: next_q = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR: next_q = {q[0], q[WIDTH-1:1]};
      default:  next_q = q;
    endcase
  end

endmodule

// File: rtl/param_shift_reg.sv
// WIDTH-bit operand/result register with synchronous clear/preset, parallel
// load, single-step shift/rotate and a multi-cycle "shift by N" engine.
// Ports:
//   clock      rising-edge clock
//   reset      synchronous active-high reset, highest priority
//   clear      synchronous active-low, forces q to all-0 and aborts
//   preset     synchronous active-low, forces q to all-1 and aborts
//   en         enables single-step ops and start acceptance (IDLE only)
//   mode       operation select (shift_pkg encoding)
//   d          parallel load data
//   ser_in_l   MSB fill bit for logical shift right
//   ser_in_r   LSB fill bit for shift left
//   start      request a multi-step shift of `amount` steps
//   amount     step count for start (0..2^AMT_W-1)
//   q          register contents
//   ser_out_l  q[WIDTH-1], combinational
//   ser_out_r  q[0], combinational
//   busy       registered, high while further steps remain
//   done       registered, one-cycle pulse after the final step
module param_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             preset,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  state_t           state;
  mode_t            op_r;
  logic [AMT_W-1:0] cnt;
  mode_t            step_op;
  logic [WIDTH-1:0] step_q;

  // A single step network serves both paths: the latched op while the
  // engine runs, the live mode otherwise.
  assign step_op = (state == ST_SHIFT) ? op_r : mode;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q        (q),
    .op       (step_op),
    .ser_in_l (ser_in_l),
    .ser_in_r (ser_in_r),
    .next_q   (step_q)
  );

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

  // Register, engine state and handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      q     <= '0;
      state <= ST_IDLE;
      op_r  <= MODE_HOLD;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!clear) begin
      q     <= '0;
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (!preset) begin
      q     <= '1;
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (en) begin
            if (start && is_shift_mode(mode)) begin
              op_r <= mode;
              if (amount == '0) begin
                // Zero-length request: no step, just the completion pulse.
                cnt   <= '0;
                state <= ST_DONE;
                done  <= 1'b1;
              end else begin
                // First step lands on the accepting edge.
                q   <= step_q;
                cnt <= amount - AMT_W'(1);
                if (amount == AMT_W'(1)) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= ST_SHIFT;
                  busy  <= 1'b1;
                end
              end
            end else if (mode == MODE_LOAD) begin
              q <= d;
            end else begin
              q <= step_q;
            end
          end
        end

        ST_SHIFT: begin
          q   <= step_q;
          cnt <= cnt - AMT_W'(1);
          // cnt holds the steps still owed; 1 means this edge is the last.
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed self-checking bench for param_shift_reg (WIDTH=8).
module tb_param_shift_reg;
  import shift_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AMT_W = $clog2(WIDTH) + 1;

  logic             clock;
  logic             reset;
  logic             clear;
  logic             preset;
  logic             en;
  mode_t            mode;
  logic [WIDTH-1:0] d;
  logic             ser_in_l;
  logic             ser_in_r;
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] q;
  logic             ser_out_l;
  logic             ser_out_r;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_fail;

  param_shift_reg #(
    .WIDTH (WIDTH),
    .AMT_W (AMT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .preset    (preset),
    .en        (en),
    .mode      (mode),
    .d         (d),
    .ser_in_l  (ser_in_l),
    .ser_in_r  (ser_in_r),
    .start     (start),
    .amount    (amount),
    .q         (q),
    .ser_out_l (ser_out_l),
    .ser_out_r (ser_out_r),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; clear = 1'b1; preset = 1'b1; en = 1'b0;
    mode = MODE_HOLD; d = '0; ser_in_l = 1'b0; ser_in_r = 1'b0;
    start = 1'b0; amount = '0;
  endtask

  task automatic load_q(input logic [WIDTH-1:0] value);
    en = 1'b1; mode = MODE_LOAD; d = value; start = 1'b0;
    tick();
    en = 1'b0; mode = MODE_HOLD;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hAA; start = 1'b1;
    amount = 4'd3; clear = 1'b0; preset = 1'b0;
    tick();
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h want 00", q); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    idle_inputs();
    tick();
  endtask

  task automatic test_clear_preset();
    load_q(8'h5A);
    clear = 1'b0; preset = 1'b0;
    tick();
    n_cmp++; if (q !== 8'h00) begin n_fail++; $display("FAIL clear_wins got %h want 00", q); end
    clear = 1'b1; preset = 1'b0;
    tick();
    n_cmp++; if (q !== 8'hFF) begin n_fail++; $display("FAIL preset got %h want FF", q); end
    n_cmp++; if ({ser_out_l, ser_out_r} !== 2'b11) begin
      n_fail++; $display("FAIL preset_ser_out got %b want 11", {ser_out_l, ser_out_r});
    end
    preset = 1'b1;
    tick();
  endtask

  task automatic test_single_step();
    mode_t            modes [6];
    logic             fill_l [6];
    logic             fill_r [6];
    logic [WIDTH-1:0] expect_q [6];
    modes    = '{MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR, MODE_RSVD};
    fill_l   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    fill_r   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    expect_q = '{8'h2D, 8'h4B, 8'hCB, 8'h2D, 8'h4B, 8'h96};
    for (int i = 0; i < 6; i++) begin
      load_q(8'h96);
      en = 1'b1; mode = modes[i]; ser_in_l = fill_l[i]; ser_in_r = fill_r[i];
      tick();
      n_cmp++; if (q !== expect_q[i]) begin
        n_fail++; $display("FAIL single_step mode=%b got %h want %h", modes[i], q, expect_q[i]);
      end
      idle_inputs();
    end
    // start with a non-shift mode behaves as a plain load
    en = 1'b1; mode = MODE_LOAD; d = 8'h33; start = 1'b1; amount = 4'd3;
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy, done} !== {8'h33, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL start_load got q=%h busy=%b done=%b want 33/0/0", q, busy, done);
    end
  endtask

  task automatic test_multi_rol();
    load_q(8'h81);
    en = 1'b1; mode = MODE_ROL; start = 1'b1; amount = 4'd3;
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy, done} !== {8'h03, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rol3_c1 got q=%h busy=%b done=%b want 03/1/0", q, busy, done);
    end
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h06, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rol3_c2 got q=%h busy=%b done=%b want 06/1/0", q, busy, done);
    end
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h0C, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rol3_c3 got q=%h busy=%b done=%b want 0C/0/1", q, busy, done);
    end
    n_cmp++; if ({ser_out_l, ser_out_r} !== 2'b00) begin
      n_fail++; $display("FAIL rol3_ser_out got %b want 00", {ser_out_l, ser_out_r});
    end
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h0C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL rol3_c4 got q=%h busy=%b done=%b want 0C/0/0", q, busy, done);
    end
  endtask

  task automatic test_amount_edges();
    int busy_cycles;
    bit seen_done;
    load_q(8'h3C);
    en = 1'b1; mode = MODE_SHL; start = 1'b1; amount = 4'd0;
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy, done} !== {8'h3C, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL amt0 got q=%h busy=%b done=%b want 3C/0/1", q, busy, done);
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL amt0_pulse got %b want 0", done); end

    load_q(8'h3C);
    en = 1'b1; mode = MODE_SHR; start = 1'b1; amount = 4'd1;
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy, done} !== {8'h1E, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL amt1 got q=%h busy=%b done=%b want 1E/0/1", q, busy, done);
    end
    tick();

    load_q(8'hA5);
    en = 1'b1; mode = MODE_ROR; start = 1'b1; amount = 4'd8;
    tick();
    idle_inputs();
    busy_cycles = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      if (done) seen_done = 1'b1;
      else begin
        if (busy) busy_cycles++;
        tick();
      end
    end
    n_cmp++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL ror8_timeout done never seen"); end
    n_cmp++; if (busy_cycles !== 7) begin n_fail++; $display("FAIL ror8_busy got %0d want 7", busy_cycles); end
    n_cmp++; if (q !== 8'hA5) begin n_fail++; $display("FAIL ror8_q got %h want A5", q); end
    tick();
  endtask

  task automatic test_abort();
    load_q(8'hFF);
    en = 1'b1; mode = MODE_SHL; start = 1'b1; amount = 4'd5; ser_in_r = 1'b0;
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy} !== {8'hFE, 1'b1}) begin
      n_fail++; $display("FAIL abort_c1 got q=%h busy=%b want FE/1", q, busy);
    end
    tick();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    n_cmp++; if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_clear got q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    end
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h00, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL abort_after got q=%h busy=%b done=%b want 00/0/0", q, busy, done);
    end
  endtask

  task automatic test_back_to_back();
    // A start request while busy must not disturb the running operation.
    load_q(8'h01);
    en = 1'b1; mode = MODE_ROL; start = 1'b1; amount = 4'd3;
    tick();
    mode = MODE_SHR; amount = 4'd7; ser_in_l = 1'b1;
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h04, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL busy_start_c2 got q=%h busy=%b done=%b want 04/1/0", q, busy, done);
    end
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h08, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL busy_start_c3 got q=%h busy=%b done=%b want 08/0/1", q, busy, done);
    end
    // Still requesting in DONE: ignored there, accepted once back in IDLE.
    tick();
    n_cmp++; if ({q, busy, done} !== {8'h08, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL done_ignores got q=%h busy=%b done=%b want 08/0/0", q, busy, done);
    end
    tick();
    idle_inputs();
    n_cmp++; if ({q, busy} !== {8'h84, 1'b1}) begin
      n_fail++; $display("FAIL restart got q=%h busy=%b want 84/1", q, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_live_fill();
    load_q(8'h00);
    en = 1'b1; mode = MODE_SHR; start = 1'b1; amount = 4'd4; ser_in_l = 1'b1;
    tick();
    en = 1'b0; start = 1'b0; mode = MODE_HOLD; ser_in_l = 1'b0;
    tick();
    ser_in_l = 1'b1;
    tick();
    ser_in_l = 1'b1;
    tick();
    n_cmp++; if ({q, done} !== {8'hD0, 1'b1}) begin
      n_fail++; $display("FAIL live_fill got q=%h done=%b want D0/1", q, done);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    idle_inputs();
    #2;
    test_reset();
    test_clear_preset();
    test_single_step();
    test_multi_rol();
    test_amount_edges();
    test_abort();
    test_back_to_back();
    test_live_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
Name: param_shift_reg

Overview:
- Parametrised successor to the single-bit flop cell: a WIDTH-bit register with synchronous clear and preset, parallel load, and single-step shift/rotate.
- Adds a multi-cycle "shift by N" engine with a busy/done handshake.
- Sits beside the 8-bit ALU datapath as the operand/result register and shifter for multi-bit shift instructions.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- AMT_W, $clog2(WIDTH)+1, width of shift-amount input, so a shift by WIDTH is encodable.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; highest priority
- clear  in  1  synchronous, active-low; forces q to all-0
- preset  in  1  synchronous, active-low; forces q to all-1
- en  in  1  enables single-step ops and start acceptance
- mode  in  3  operation select
- d  in  WIDTH  parallel load data
- ser_in_l  in  1  fill bit entering at MSB (logical shift right)
- ser_in_r  in  1  fill bit entering at LSB (shift left)
- start  in  1  request multi-cycle shift of amount steps
- amount  in  AMT_W  number of steps for start
- q  out  WIDTH  register contents
- ser_out_l  out  1  q[WIDTH-1], combinational from q
- ser_out_r  out  1  q[0], combinational from q
- busy  out  1  multi-cycle shift in progress
- done  out  1  one-cycle pulse after the last step

Behaviour:
- Mode encoding:
  - 000 hold
  - 001 load d
  - 010 shl, LSB <= ser_in_r
  - 011 shr, MSB <= ser_in_l
  - 100 asr, MSB replicated
  - 101 rol
  - 110 ror
  - 111 reserved, acts as hold
- Priority per edge:
  - reset: q=0, state IDLE, busy=0, done=0, counter=0.
  - Else clear==0: q=0, abort to IDLE, no done.
  - Else preset==0: q=all-1, abort to IDLE, no done.
  - Else FSM.
  - clear and preset both low: clear wins.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - en=1, start=0: apply mode once at the edge (1-cycle latency).
  - en=1, start=1, mode in 010..110, amount>=1: latch mode into op_r, load cnt=amount, apply the first step on the same edge, cnt-1. Go to DONE if amount==1, else SHIFT.
  - en=1, start=1, amount==0: q unchanged, go to DONE.
  - en=1, start=1, mode in {000,001,111}: treated as single-step; start ignored.
  - en=0: hold; start ignored.
- SHIFT:
  - busy=1.
  - Each edge applies op_r once and decrements cnt.
  - The edge applying the final step moves to DONE.
  - en, mode, start, amount are ignored.
  - Serial fill bits are sampled live each cycle.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
  - Inputs are ignored in DONE; a new start is accepted from IDLE only.
- Timing: for amount=N>=1, busy is high for N-1 cycles and done pulses on cycle N after the start edge. The total is N step-edges.
- amount > WIDTH is legal:
  - Rotates wrap modulo WIDTH.
  - Shifts saturate to fill-bit content.
- busy and done are registered outputs; reset value 0.

Decomposition:
- Package shift_pkg:
  - mode encoding constants (MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ASR, MODE_ROL, MODE_ROR)
  - FSM state enum
  - function is_shift_mode
- Sub-module shift_step: purely combinational; inputs q, op, ser_in_l, ser_in_r; outputs next q for one step.
  - Instantiated once and shared by the single-step and SHIFT paths.

Test Plan:
- Reset / clear / preset:
  - reset=1 with any inputs -> q=0x00, busy=0, done=0 next edge.
  - clear=0 with preset=0 -> q=0x00.
  - preset=0 alone -> q=0xFF.
- Single steps, WIDTH=8, en=1, start=0, q loaded 0x96 via mode 001:
  - shl, ser_in_r=1 -> 0x2D
  - shr, ser_in_l=0 -> 0x4B
  - asr -> 0xCB
  - rol -> 0x2D
  - ror -> 0x4B
  - mode 111 -> 0x96 unchanged
- Multi-shift, q=0x81, mode rol, amount=3, start=1:
  - busy high 2 cycles; done pulses on cycle 3; q=0x0C.
  - ser_out_l=0, ser_out_r=0.
- Edge amounts:
  - amount=0 -> done next cycle, q unchanged.
  - amount=1 -> no busy cycle, done next.
  - amount=8 with ror on 0xA5 -> q=0xA5 after 8 steps.
- Abort and ignored requests:
  - Start shl amount=5 on 0xFF; drive clear=0 on the 3rd cycle -> q=0x00, busy=0 next edge, no done pulse.
  - start asserted during busy -> ignored, cnt unaffected.
- Live serial fill: shr amount=4 on 0x00 with ser_in_l toggling 1,0,1,1 per cycle -> q=0xD0.
